// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision add/sub datapath.
// The operand-align stage and the stages after it agree on these bundles.
package fp_pkg;

    localparam int WIDTH = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int SIG_W = MAN_W + 1;
    localparam int ALN_W = MAN_W + 4;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    // Compare/swap result held between the two pipeline stages
    typedef struct packed {
        logic             sign_l;
        logic [EXP_W-1:0] exp_l;
        logic [SIG_W-1:0] sig_l;
        logic [SIG_W-1:0] sig_s;
        logic [EXP_W-1:0] diff;
        logic             eff_sub;
        logic             swap;
        logic [1:0]       special;
    } stage1_t;

    typedef struct packed {
        logic             sign_l;
        logic [EXP_W-1:0] exp;
        logic [ALN_W-1:0] mant_l;
        logic [ALN_W-1:0] mant_s;
        logic             eff_sub;
        logic             swap;
        logic [1:0]       special;
    } align_bundle_t;

    // Denormals and zero share the minimum normal exponent
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

endpackage

// File: rtl/fp_sticky_shifter.sv
// Right shift of an aligned significand; every bit pushed out of the
// word is collapsed into bit 0 as the sticky bit.
module fp_sticky_shifter #(
    parameter int W    = 27,
    parameter int SH_W = 8
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] shamt,
    output logic [W-1:0]    dout
);

    localparam logic [SH_W-1:0] W_SH = SH_W'(W);

    logic [W-1:0] lost;
    logic [W-1:0] shifted;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_lost
            localparam logic [SH_W-1:0] POS = SH_W'(gi);
            assign lost[gi] = din[gi] & (shamt > POS);
        end
    endgenerate

    assign shifted = din >> shamt;

    // Shifting the whole word out leaves only the sticky indication
    assign dout = (shamt >= W_SH) ? {{(W-1){1'b0}}, |din}
                                  : {shifted[W-1:1], shifted[0] | (|lost)};

endmodule

// File: rtl/fp_operand_align.sv
// Pre-adder stage: orders operands by magnitude, resolves the effective
// operation and aligns the smaller significand with guard/round/sticky.
module fp_operand_align #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             operation_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign_l,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W+3:0] out_mant_l,
    output logic [MAN_W+3:0] out_mant_s,
    output logic             out_eff_sub,
    output logic             out_swap,
    output logic [1:0]       out_special
);

    import fp_pkg::*;

    fp32_t            x_f, y_f;
    logic [EXP_W-1:0] ex, ey;
    logic [SIG_W-1:0] sig_x, sig_y;
    logic             sign_y_eff;
    logic             swap_c;
    logic             nan_any, inf_any;

    stage1_t          s1_d, s1_q;
    align_bundle_t    s2_d, s2_q;
    logic             s1_v_d, s1_v_q;
    logic             s2_v_d, s2_v_q;
    logic             s1_adv;
    logic [ALN_W-1:0] shift_out;

    assign x_f = fp32_t'(X);
    assign y_f = fp32_t'(Y);

    assign ex    = eff_exp(x_f.exp);
    assign ey    = eff_exp(y_f.exp);
    assign sig_x = {x_f.exp != '0, x_f.frac};
    assign sig_y = {y_f.exp != '0, y_f.frac};

    // Subtraction is folded into Y's sign before any ordering happens
    assign sign_y_eff = operation_select ? y_f.sign : ~y_f.sign;
    assign swap_c     = (ey > ex) || ((ey == ex) && (y_f.frac > x_f.frac));

    assign nan_any = ((&x_f.exp) & (|x_f.frac)) | ((&y_f.exp) & (|y_f.frac));
    assign inf_any = ((&x_f.exp) & ~(|x_f.frac)) | ((&y_f.exp) & ~(|y_f.frac));

    assign s1_adv   = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s1_adv;

    always_comb begin
        s1_v_d = s1_v_q;
        s1_d   = s1_q;
        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_d.sign_l  = swap_c ? sign_y_eff : x_f.sign;
                s1_d.exp_l   = swap_c ? ey : ex;
                s1_d.sig_l   = swap_c ? sig_y : sig_x;
                s1_d.sig_s   = swap_c ? sig_x : sig_y;
                s1_d.diff    = swap_c ? (ey - ex) : (ex - ey);
                s1_d.eff_sub = x_f.sign ^ sign_y_eff;
                s1_d.swap    = swap_c;
                s1_d.special = {nan_any, inf_any};
            end
        end
    end

    fp_sticky_shifter #(
        .W    (ALN_W),
        .SH_W (EXP_W)
    ) u_shift (
        .din   ({s1_q.sig_s, 3'b000}),
        .shamt (s1_q.diff),
        .dout  (shift_out)
    );

    always_comb begin
        s2_v_d = s2_v_q;
        s2_d   = s2_q;
        if (s1_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_d.sign_l  = s1_q.sign_l;
                s2_d.exp     = s1_q.exp_l;
                s2_d.mant_l  = {s1_q.sig_l, 3'b000};
                s2_d.mant_s  = shift_out;
                s2_d.eff_sub = s1_q.eff_sub;
                s2_d.swap    = s1_q.swap;
                s2_d.special = s1_q.special;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end

    assign out_valid   = s2_v_q;
    assign out_sign_l  = s2_q.sign_l;
    assign out_exp     = s2_q.exp;
    assign out_mant_l  = s2_q.mant_l;
    assign out_mant_s  = s2_q.mant_s;
    assign out_eff_sub = s2_q.eff_sub;
    assign out_swap    = s2_q.swap;
    assign out_special = s2_q.special;

endmodule

// File: tb/tb_fp_operand_align.sv
// Bench for fp_operand_align: table vectors, random stream under random
// backpressure, a held-output sequence and a mid-flight reset.
module tb_fp_operand_align;

    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign_l;
    logic [7:0]  out_exp;
    logic [26:0] out_mant_l;
    logic [26:0] out_mant_s;
    logic        out_eff_sub;
    logic        out_swap;
    logic [1:0]  out_special;

    int total = 0;
    int bad   = 0;

    // 0: always ready, 1: stalled, 2: random
    int   bp_mode   = 0;
    logic rnd_ready = 1'b1;
    assign out_ready = (bp_mode == 0) | ((bp_mode == 2) & rnd_ready);

    always #5 clk = ~clk;

    fp_operand_align dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .X                (X),
        .Y                (Y),
        .operation_select (op),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sign_l       (out_sign_l),
        .out_exp          (out_exp),
        .out_mant_l       (out_mant_l),
        .out_mant_s       (out_mant_s),
        .out_eff_sub      (out_eff_sub),
        .out_swap         (out_swap),
        .out_special      (out_special)
    );

    align_bundle_t act;
    assign act = {out_sign_l, out_exp, out_mant_l, out_mant_s, out_eff_sub, out_swap, out_special};

    typedef struct {
        logic [31:0]   x;
        logic [31:0]   y;
        logic          op;
        align_bundle_t e;
    } vec_t;

    vec_t          tbl[12];
    align_bundle_t sb_q[$];
    align_bundle_t exp_cur;
    align_bundle_t prev_act;
    logic          prev_hold = 1'b0;

    task automatic check_bundle(input string name, input align_bundle_t a, input align_bundle_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got sl=%0b exp=%h ml=%h ms=%h sub=%0b sw=%0b sp=%b, want sl=%0b exp=%h ml=%h ms=%h sub=%0b sw=%0b sp=%b",
                     name, a.sign_l, a.exp, a.mant_l, a.mant_s, a.eff_sub, a.swap, a.special,
                     e.sign_l, e.exp, e.mant_l, e.mant_s, e.eff_sub, e.swap, e.special);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    function automatic align_bundle_t mkb(input logic sl, input logic [7:0] e, input logic [26:0] ml,
                                          input logic [26:0] ms, input logic sub, input logic sw,
                                          input logic [1:0] sp);
        align_bundle_t r;
        r.sign_l = sl; r.exp = e; r.mant_l = ml; r.mant_s = ms;
        r.eff_sub = sub; r.swap = sw; r.special = sp;
        return r;
    endfunction

    // Independent reference: wide-window shift, sticky taken from the spill bits
    function automatic align_bundle_t model(input logic [31:0] x, input logic [31:0] y, input logic o);
        logic [7:0]    ex, ey, el, es, d;
        logic [23:0]   mx, my, ml, ms;
        logic          sx, sy, big_y;
        logic [53:0]   w;
        align_bundle_t r;
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {|x[30:23], x[22:0]};
        my = {|y[30:23], y[22:0]};
        sx = x[31];
        sy = y[31] ^ ~o;
        big_y = {ey, y[22:0]} > {ex, x[22:0]};
        el = big_y ? ey : ex;
        es = big_y ? ex : ey;
        ml = big_y ? my : mx;
        ms = big_y ? mx : my;
        d  = el - es;
        r.sign_l  = big_y ? sy : sx;
        r.exp     = el;
        r.mant_l  = {ml, 3'b000};
        if (d >= 8'd27) begin
            r.mant_s = {26'd0, |ms};
        end else begin
            w = {ms, 3'b000, 27'd0} >> d;
            r.mant_s = {w[53:28], w[27] | (|w[26:0])};
        end
        r.eff_sub = sx ^ sy;
        r.swap    = big_y;
        r.special = {((&x[30:23]) & (|x[22:0])) | ((&y[30:23]) & (|y[22:0])),
                     ((&x[30:23]) & ~(|x[22:0])) | ((&y[30:23]) & ~(|y[22:0]))};
        return r;
    endfunction

    // Output scoreboard, input capture and hold-stability, all sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                check_val("hold_valid", {31'd0, out_valid}, 32'd1);
                check_bundle("hold_stable", act, prev_act);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got exp=%h ms=%h want no output", act.exp, act.mant_s);
                end else begin
                    check_bundle("out", act, sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) sb_q.push_back(exp_cur);
            prev_hold = out_valid && !out_ready;
            prev_act  = act;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic o, input align_bundle_t e);
        logic ok;
        ok       = 1'b0;
        exp_cur  = e;
        X        = x;
        Y        = y;
        op       = o;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles want 1");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
        end
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic        ro;

        tbl[0]  = '{32'h3F800000, 32'h3F800000, 1'b1, mkb(1'b0, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 2'b00)};
        tbl[1]  = '{32'h3F800000, 32'h40000000, 1'b0, mkb(1'b1, 8'h80, 27'h4000000, 27'h2000000, 1'b1, 1'b1, 2'b00)};
        tbl[2]  = '{32'h3F800000, 32'h30800000, 1'b1, mkb(1'b0, 8'h7F, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 2'b00)};
        tbl[3]  = '{32'h7FC00000, 32'h3F800000, 1'b1, mkb(1'b0, 8'hFF, 27'h6000000, 27'h0000001, 1'b0, 1'b0, 2'b10)};
        tbl[4]  = '{32'h7F800000, 32'h3F800000, 1'b1, mkb(1'b0, 8'hFF, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 2'b01)};
        tbl[5]  = '{32'h00000000, 32'h00000000, 1'b1, mkb(1'b0, 8'h01, 27'h0000000, 27'h0000000, 1'b0, 1'b0, 2'b00)};
        tbl[6]  = '{32'h00000004, 32'h00000010, 1'b0, mkb(1'b1, 8'h01, 27'h0000080, 27'h0000020, 1'b1, 1'b1, 2'b00)};
        tbl[7]  = '{32'h3F800000, 32'h3B800001, 1'b1, mkb(1'b0, 8'h7F, 27'h4000000, 27'h0040001, 1'b0, 1'b0, 2'b00)};
        tbl[8]  = '{32'h3F800000, 32'h33000000, 1'b1, mkb(1'b0, 8'h7F, 27'h4000000, 27'h0000002, 1'b0, 1'b0, 2'b00)};
        tbl[9]  = '{32'h3F800000, 32'h32000000, 1'b1, mkb(1'b0, 8'h7F, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 2'b00)};
        tbl[10] = '{32'hBF800000, 32'h3F800000, 1'b1, mkb(1'b1, 8'h7F, 27'h4000000, 27'h4000000, 1'b1, 1'b0, 2'b00)};
        tbl[11] = '{32'h3F800000, 32'hFF800000, 1'b0, mkb(1'b0, 8'hFF, 27'h4000000, 27'h0000001, 1'b0, 1'b1, 2'b01)};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_bundle("rst_outputs", act, '0);
        rst_n = 1'b1;

        // Directed table, back-to-back
        for (int i = 0; i < 12; i++) send(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].e);
        wait_drain();

        // Random stream under random backpressure
        bp_mode = 2;
        for (int i = 0; i < 40; i++) begin
            rx = $urandom;
            ry = $urandom;
            ro = 1'($urandom_range(0, 1));
            if (i % 3 == 1) ry[30:23] = rx[30:23] - 8'($urandom_range(0, 30));
            if (i % 3 == 2) ry[30:23] = rx[30:23];
            send(rx, ry, ro, model(rx, ry, ro));
        end
        bp_mode = 0;
        wait_drain();

        // Stall: two accepted fill the pipe, in_ready must drop
        bp_mode = 1;
        send(32'h40400000, 32'h3F800000, 1'b1, model(32'h40400000, 32'h3F800000, 1'b1));
        send(32'h40800000, 32'h3E800000, 1'b0, model(32'h40800000, 32'h3E800000, 1'b0));
        check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
        fork
            send(32'h41000000, 32'h41100000, 1'b1, model(32'h41000000, 32'h41100000, 1'b1));
            begin
                repeat (3) @(posedge clk);
                #1;
                bp_mode = 0;
            end
        join
        send(32'hC1200000, 32'h3A000007, 1'b0, model(32'hC1200000, 32'h3A000007, 1'b0));
        wait_drain();

        // Reset with two items in flight
        bp_mode = 1;
        send(32'h3F800000, 32'h3F800000, 1'b1, tbl[0].e);
        send(32'h3F800000, 32'h40000000, 1'b0, tbl[1].e);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check_bundle("arst_outputs", act, '0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bp_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check_val("post_rst_valid", {31'd0, out_valid}, 32'd0);
        send(tbl[2].x, tbl[2].y, tbl[2].op, tbl[2].e);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
